// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters.
// In-flight reads ride an ID-tagged delay pipe that steers read data back to the issuer.
module spram_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 13,
  parameter int unsigned DEPTH   = 6240,
  parameter int unsigned N_DELAY = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp0_err,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          rsp1_err,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int unsigned PD = N_DELAY + 1;

  logic          prio_q, prio_d;
  logic          gnt0, gnt1, accept;
  logic          sel_we, in_range;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          mem_cs_q, mem_cs_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [PD-1:0] pipe_v_q, pipe_v_d;
  logic [PD-1:0] pipe_id_q, pipe_id_d;
  logic [PD-1:0] pipe_err_q, pipe_err_d;
  logic          out_v, out_id, out_err;

  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic          rsp0_err_q, rsp0_err_d;
  logic          rsp1_err_q, rsp1_err_d;
  logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;

  // Grants are masked by reset so nothing is accepted while the pipe is being cleared.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      gnt0 = req0_valid && (!req1_valid || !prio_q);
      gnt1 = req1_valid && (!req0_valid || prio_q);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign sel_we     = gnt1 ? req1_we    : req0_we;
  assign sel_addr   = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata  = gnt1 ? req1_wdata : req0_wdata;
  assign in_range   = 32'(sel_addr) < DEPTH;

  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;

    mem_cs_d    = accept && in_range;
    mem_we_d    = accept && in_range && sel_we;
    mem_addr_d  = mem_cs_d ? sel_addr  : mem_addr_q;
    mem_wdata_d = mem_cs_d ? sel_wdata : mem_wdata_q;
  end

  // Stage N_DELAY lines up with the cycle the SRAM presents read data.
  assign out_v   = pipe_v_q[PD-1];
  assign out_id  = pipe_id_q[PD-1];
  assign out_err = pipe_err_q[PD-1];

  always_comb begin
    pipe_v_d   = {pipe_v_q[PD-2:0],   accept && !sel_we};
    pipe_id_d  = {pipe_id_q[PD-2:0],  gnt1};
    pipe_err_d = {pipe_err_q[PD-2:0], !in_range};

    rsp0_valid_d = out_v && !out_id;
    rsp1_valid_d = out_v && out_id;
    rsp0_err_d   = rsp0_valid_d && out_err;
    rsp1_err_d   = rsp1_valid_d && out_err;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (rsp0_valid_d) rsp0_rdata_d = out_err ? '0 : mem_rdata;
    if (rsp1_valid_d) rsp1_rdata_d = out_err ? '0 : mem_rdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_q       <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pipe_v_q     <= '0;
      pipe_id_q    <= '0;
      pipe_err_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      prio_q       <= prio_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pipe_v_q     <= pipe_v_d;
      pipe_id_q    <= pipe_id_d;
      pipe_err_q   <= pipe_err_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_err   = rsp1_err_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: two instances (read latency 1 and 2) share one stimulus stream,
// each with its own SRAM; a transaction-level model predicts every output each cycle.
module tb_spram_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_we = 1'b0, req1_we = 1'b0;
  logic [12:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;

  logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_re0, a_re1, a_cs, a_we;
  logic [31:0] a_rd0, a_rd1, a_wd, a_mrd;
  logic [12:0] a_addr;
  logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_re0, b_re1, b_cs, b_we;
  logic [31:0] b_rd0, b_rd1, b_wd, b_mrd, b_pipe;
  logic [12:0] b_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spram_arbiter #(.DW(32), .AW(13), .DEPTH(6240), .N_DELAY(1)) u_a (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(a_rdy0), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(a_rdy1), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(a_rv0), .rsp0_rdata(a_rd0), .rsp0_err(a_re0),
    .rsp1_valid(a_rv1), .rsp1_rdata(a_rd1), .rsp1_err(a_re1),
    .mem_cs(a_cs), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wd), .mem_rdata(a_mrd));

  spram_arbiter #(.DW(32), .AW(13), .DEPTH(6240), .N_DELAY(2)) u_b (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(b_rdy0), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(b_rdy1), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(b_rv0), .rsp0_rdata(b_rd0), .rsp0_err(b_re0),
    .rsp1_valid(b_rv1), .rsp1_rdata(b_rd1), .rsp1_err(b_re1),
    .mem_cs(b_cs), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd), .mem_rdata(b_mrd));

  // Behavioural SRAMs: latency 1 and latency 2
  logic [31:0] sram_a [0:6239];
  logic [31:0] sram_b [0:6239];
  initial begin
    for (int unsigned i = 0; i < 6240; i++) begin
      sram_a[i] = '0;
      sram_b[i] = '0;
    end
    a_mrd  = '0;
    b_mrd  = '0;
    b_pipe = '0;
  end
  always @(posedge clk) begin
    if (a_cs) begin
      if (a_we) sram_a[a_addr] <= a_wd;
      else      a_mrd <= sram_a[a_addr];
    end
  end
  always @(posedge clk) begin
    if (b_cs) begin
      if (b_we) sram_b[b_addr] <= b_wd;
      else      b_pipe <= sram_b[b_addr];
    end
    b_mrd <= b_pipe;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model state
  typedef struct {
    int      due;
    bit      id;
    bit [31:0] data;
    bit      err;
  } rsp_t;

  bit [31:0] mmem [0:6239];
  rsp_t      eq [2][$];
  bit [31:0] lastd [2][2];
  bit        mprio;
  bit        exp_cs, exp_we;
  bit [12:0] exp_addr;
  bit [31:0] exp_wd;
  int        win;

  task automatic cmp_dut(input int k, input logic rdy0, rdy1, cs, we, input logic [12:0] addr,
                         input logic [31:0] wd, input logic rv0, rv1, re0, re1,
                         input logic [31:0] rd0, rd1);
    bit   ev [2];
    bit   ee [2];
    rsp_t e;
    string p;
    p = $sformatf("d%0d_", k);
    ev = '{1'b0, 1'b0};
    ee = '{1'b0, 1'b0};
    if (eq[k].size() != 0 && eq[k][0].due == cyc) begin
      e = eq[k].pop_front();
      ev[e.id] = 1'b1;
      ee[e.id] = e.err;
      lastd[k][e.id] = e.data;
    end
    chk({p, "ready0"}, 32'(rdy0), 32'(win == 0));
    chk({p, "ready1"}, 32'(rdy1), 32'(win == 1));
    chk({p, "mem_cs"}, 32'(cs), 32'(exp_cs));
    chk({p, "mem_we"}, 32'(we), 32'(exp_we));
    chk({p, "mem_addr"}, 32'(addr), 32'(exp_addr));
    chk({p, "mem_wdata"}, wd, exp_wd);
    chk({p, "rsp0_valid"}, 32'(rv0), 32'(ev[0]));
    chk({p, "rsp1_valid"}, 32'(rv1), 32'(ev[1]));
    chk({p, "rsp0_err"}, 32'(re0), 32'(ee[0]));
    chk({p, "rsp1_err"}, 32'(re1), 32'(ee[1]));
    chk({p, "rsp0_rdata"}, rd0, lastd[k][0]);
    chk({p, "rsp1_rdata"}, rd1, lastd[k][1]);
  endtask

  initial begin
    bit [12:0] a;
    bit        w, inr;
    bit [31:0] d;
    rsp_t      r;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        win = -1;
        mprio = 1'b0;
        exp_cs = 1'b0;
        exp_we = 1'b0;
        exp_addr = '0;
        exp_wd = '0;
        for (int k = 0; k < 2; k++) begin
          eq[k].delete();
          lastd[k][0] = '0;
          lastd[k][1] = '0;
        end
      end else begin
        if (req0_valid && req1_valid) win = int'(mprio);
        else if (req0_valid)          win = 0;
        else if (req1_valid)          win = 1;
        else                          win = -1;
      end
      cmp_dut(0, a_rdy0, a_rdy1, a_cs, a_we, a_addr, a_wd, a_rv0, a_rv1, a_re0, a_re1, a_rd0, a_rd1);
      cmp_dut(1, b_rdy0, b_rdy1, b_cs, b_we, b_addr, b_wd, b_rv0, b_rv1, b_re0, b_re1, b_rd0, b_rd1);
      exp_cs = 1'b0;
      exp_we = 1'b0;
      if (win >= 0) begin
        a   = (win == 1) ? req1_addr  : req0_addr;
        w   = (win == 1) ? req1_we    : req0_we;
        d   = (win == 1) ? req1_wdata : req0_wdata;
        inr = (a < 13'd6240);
        if (inr) begin
          exp_cs = 1'b1;
          exp_we = w;
          exp_addr = a;
          exp_wd = d;
        end
        if (w) begin
          if (inr) mmem[a] = d;
        end else begin
          r.id   = (win == 1);
          r.err  = !inr;
          r.data = inr ? mmem[a] : 32'h0;
          r.due  = cyc + 3;
          eq[0].push_back(r);
          r.due  = cyc + 4;
          eq[1].push_back(r);
        end
        mprio = (win == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, we, input logic [12:0] ad, input logic [31:0] dt);
    req0_valid = v; req0_we = we; req0_addr = ad; req0_wdata = dt;
  endtask

  task automatic drv1(input logic v, we, input logic [12:0] ad, input logic [31:0] dt);
    req1_valid = v; req1_we = we; req1_addr = ad; req1_wdata = dt;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset with both requesters pushing
    rstn = 1'b0;
    drv0(1'b1, 1'b0, 13'd0, '0);
    drv1(1'b1, 1'b0, 13'd0, '0);
    repeat (3) tick();
    @(negedge clk);
    chk("lit_rst_ready0", 32'(a_rdy0), 32'd0);
    chk("lit_rst_ready1", 32'(a_rdy1), 32'd0);
    chk("lit_rst_cs", 32'(a_cs), 32'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_ready0", 32'(a_rdy0), 32'd1);
    chk("lit_post_rst_ready1", 32'(a_rdy1), 32'd0);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("lit_post_rst_second", 32'(a_rdy1), 32'd1);
    tick();
    idle();
    repeat (4) tick();

    // Single requester: 16 writes then 16 reads back-to-back
    for (int i = 0; i < 16; i++) begin
      drv0(1'b1, 1'b1, 13'(i), 32'(i) * 32'h11111111);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drv0(1'b1, 1'b0, 13'(i), '0);
      tick();
    end
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("lit_single_last_v_d1", 32'(a_rv0), 32'd1);
    chk("lit_single_last_d_d1", a_rd0, 32'hFFFFFFFF);
    tick();
    @(negedge clk);
    chk("lit_single_last_v_d2", 32'(b_rv0), 32'd1);
    chk("lit_single_last_d_d2", b_rd0, 32'hFFFFFFFF);
    chk("lit_single_done_d1", 32'(a_rv0), 32'd0);
    repeat (3) tick();

    // Fairness after idle
    drv1(1'b1, 1'b0, 13'd7, '0);
    @(negedge clk);
    chk("lit_fair_alone1", 32'(a_rdy1), 32'd1);
    tick();
    drv1(1'b1, 1'b0, 13'd5, '0);
    drv0(1'b1, 1'b0, 13'd3, '0);
    @(negedge clk);
    chk("lit_fair_first0", 32'(a_rdy0), 32'd1);
    chk("lit_fair_first1", 32'(a_rdy1), 32'd0);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("lit_fair_then1", 32'(a_rdy1), 32'd1);
    tick();
    idle();
    repeat (4) tick();

    // Contention: both valid four cycles
    drv0(1'b1, 1'b0, 13'd3, '0);
    drv1(1'b1, 1'b0, 13'd5, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_cont_ready0", 32'(a_rdy0), 32'((k % 2) == 0));
      if (k == 3) begin
        chk("lit_cont_rsp0_v", 32'(a_rv0), 32'd1);
        chk("lit_cont_rsp0_d", a_rd0, 32'h33333333);
      end
      tick();
    end
    idle();
    @(negedge clk);
    chk("lit_cont_rsp1_v", 32'(a_rv1), 32'd1);
    chk("lit_cont_rsp1_d", a_rd1, 32'h55555555);
    chk("lit_cont_rsp0_quiet", 32'(a_rv0), 32'd0);
    repeat (6) tick();

    // Out-of-range read and write
    drv1(1'b1, 1'b0, 13'd6240, '0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_oor_rd_cs", 32'(a_cs), 32'd0);
    tick();
    tick();
    @(negedge clk);
    chk("lit_oor_rd_v", 32'(a_rv1), 32'd1);
    chk("lit_oor_rd_err", 32'(a_re1), 32'd1);
    chk("lit_oor_rd_data", a_rd1, 32'd0);
    tick();
    drv0(1'b1, 1'b1, 13'd8191, 32'hDEADBEEF);
    tick();
    idle();
    @(negedge clk);
    chk("lit_oor_wr_cs", 32'(a_cs), 32'd0);
    tick();
    drv0(1'b1, 1'b0, 13'd0, '0);
    tick();
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("lit_oor_addr0_v", 32'(a_rv0), 32'd1);
    chk("lit_oor_addr0_d", a_rd0, 32'd0);
    repeat (4) tick();

    // Reset pulse with two reads in flight
    drv0(1'b1, 1'b0, 13'd1, '0);
    tick();
    drv0(1'b1, 1'b0, 13'd2, '0);
    tick();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_rstmid_quiet_d1", 32'(a_rv0), 32'd0);
      chk("lit_rstmid_quiet_d2", 32'(b_rv0), 32'd0);
      tick();
    end
    drv0(1'b1, 1'b0, 13'd4, '0);
    tick();
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("lit_rstmid_after_v_d1", 32'(a_rv0), 32'd1);
    chk("lit_rstmid_after_d_d1", a_rd0, 32'h44444444);
    tick();
    @(negedge clk);
    chk("lit_rstmid_after_v_d2", 32'(b_rv0), 32'd1);
    chk("lit_rstmid_after_d_d2", b_rd0, 32'h44444444);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
